// File: rtl/fifo_wr_ptr_gen_if.sv
// Write-port bundle for fifo_wr_ptr_gen: the request and read-pointer inputs,
// plus the pointer and status outputs going to memory, the read domain and the user.
interface fifo_wr_ptr_gen_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic                  full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;
  logic                  wr_mem_en;

  // master is the write-port user; slave is the pointer generator itself
  modport master (
    output wr_en, rd_ptr_gray,
    input  wr_addr, wr_ptr_gray, full, wr_level, overflow, wr_mem_en
  );

  modport slave (
    input  wr_en, rd_ptr_gray,
    output wr_addr, wr_ptr_gray, full, wr_level, overflow, wr_mem_en
  );
endinterface

// File: rtl/fifo_wr_ptr_gen.sv
// Write-side pointer generator for the async FIFO: binary/Gray write pointer, full, level, overflow.
// Define FIFO_WR_PTR_SYNC_EN to add an internal 2-flop synchronizer on rd_ptr_gray.
module fifo_wr_ptr_gen #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  fifo_wr_ptr_gen_if.slave wr_if
);
  localparam int A = ADDR_WIDTH;

  logic [A:0] wr_bin;
  logic [A:0] wr_bin_next;
  logic [A:0] wr_gray_next;
  logic [A:0] wr_gray_q;
  logic [A:0] full_ptr;
  logic [A:0] rq;
  logic [A:0] rq_bin;
  logic [A:0] level_q;
  logic       full_q;
  logic       overflow_q;
  logic       inc;

`ifdef FIFO_WR_PTR_SYNC_EN
  logic [A:0] sync_q1;
  logic [A:0] sync_q2;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= wr_if.rd_ptr_gray;
      sync_q2 <= sync_q1;
    end
  end

  assign rq = sync_q2;
`else
  assign rq = wr_if.rd_ptr_gray;
`endif

  // Gray to binary: each bit is the XOR of all Gray bits from the MSB down to it
  always_comb begin
    rq_bin = '0;
    for (int i = 0; i <= A; i++) begin
      rq_bin[i] = ^(rq >> i);
    end
  end

  assign inc          = wr_if.wr_en & ~full_q;
  assign wr_bin_next  = wr_bin + {{A{1'b0}}, inc};
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
  assign full_ptr     = {~rq[A:A-1], rq[A-2:0]};

  // Status is computed from the next write pointer so a write and a read-pointer move on one edge both count
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin     <= '0;
      wr_gray_q  <= '0;
      full_q     <= 1'b0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin     <= wr_bin_next;
      wr_gray_q  <= wr_gray_next;
      full_q     <= (wr_gray_next == full_ptr);
      level_q    <= wr_bin_next - rq_bin;
      overflow_q <= wr_if.wr_en & full_q;
    end
  end

  assign wr_if.wr_addr     = wr_bin[A-1:0];
  assign wr_if.wr_ptr_gray = wr_gray_q;
  assign wr_if.full        = full_q;
  assign wr_if.wr_level    = level_q;
  assign wr_if.overflow    = overflow_q;
  assign wr_if.wr_mem_en   = inc;
endmodule

// File: tb/tb_fifo_wr_ptr_gen.sv
// Self-checking bench for fifo_wr_ptr_gen with ADDR_WIDTH=2: directed vector table
// plus hand sequences for reset, release latency and mid-operation reset.
module tb_fifo_wr_ptr_gen;
  localparam int AW = 2;

  logic wr_clk;
  logic wr_rst_n;
  int   num_checks;
  int   num_fail;

  fifo_wr_ptr_gen_if #(.ADDR_WIDTH(AW)) wr_if ();

  fifo_wr_ptr_gen #(.ADDR_WIDTH(AW)) dut (
    .wr_clk  (wr_clk),
    .wr_rst_n(wr_rst_n),
    .wr_if   (wr_if)
  );

  typedef struct {
    logic       wr_en;
    logic [2:0] rd;
    logic       exp_mem_en;
    logic [1:0] exp_addr;
    logic [2:0] exp_gray;
    logic       exp_full;
    logic [2:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [17];

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] rd);
    wr_if.wr_en       = we;
    wr_if.rd_ptr_gray = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] addr, input logic [2:0] gray,
                             input logic full, input logic [2:0] level, input logic ovf);
    checkValue($sformatf("%s addr", tag), 32'(wr_if.wr_addr), 32'(addr));
    checkValue($sformatf("%s gray", tag), 32'(wr_if.wr_ptr_gray), 32'(gray));
    checkValue($sformatf("%s full", tag), 32'(wr_if.full), 32'(full));
    checkValue($sformatf("%s level", tag), 32'(wr_if.wr_level), 32'(level));
    checkValue($sformatf("%s overflow", tag), 32'(wr_if.overflow), 32'(ovf));
  endtask

  // Drive inputs away from the edge, check the combinational strobe, then the registered outputs
  task automatic stepAndCheck(input string tag, input logic we, input logic [2:0] rd, input logic mem_en,
                              input logic [1:0] addr, input logic [2:0] gray, input logic full,
                              input logic [2:0] level, input logic ovf);
    applyStimulus(we, rd);
    #1;
    checkValue($sformatf("%s mem_en", tag), 32'(wr_if.wr_mem_en), 32'(mem_en));
    @(posedge wr_clk);
    #1;
    checkOutput(tag, addr, gray, full, level, ovf);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_checks = 0;
    num_fail   = 0;

    //            we    rd      mem   addr  gray    full  lvl   ovf
    vecs[0]  = '{1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 3'd1, 1'b0};
    vecs[1]  = '{1'b1, 3'b000, 1'b1, 2'd2, 3'b011, 1'b0, 3'd2, 1'b0};
    vecs[2]  = '{1'b1, 3'b000, 1'b1, 2'd3, 3'b010, 1'b0, 3'd3, 1'b0};
    vecs[3]  = '{1'b1, 3'b000, 1'b1, 2'd0, 3'b110, 1'b1, 3'd4, 1'b0};
    vecs[4]  = '{1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b1};
    vecs[5]  = '{1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b1};
    vecs[6]  = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 3'd3, 1'b0};
    vecs[7]  = '{1'b1, 3'b011, 1'b1, 2'd1, 3'b111, 1'b0, 3'd3, 1'b0};
    vecs[8]  = '{1'b1, 3'b010, 1'b1, 2'd2, 3'b101, 1'b0, 3'd3, 1'b0};
    vecs[9]  = '{1'b1, 3'b110, 1'b1, 2'd3, 3'b100, 1'b0, 3'd3, 1'b0};
    vecs[10] = '{1'b1, 3'b111, 1'b1, 2'd0, 3'b000, 1'b0, 3'd3, 1'b0};
    vecs[11] = '{1'b1, 3'b101, 1'b1, 2'd1, 3'b001, 1'b0, 3'd3, 1'b0};
    vecs[12] = '{1'b0, 3'b100, 1'b0, 2'd1, 3'b001, 1'b0, 3'd2, 1'b0};
    vecs[13] = '{1'b1, 3'b100, 1'b1, 2'd2, 3'b011, 1'b0, 3'd3, 1'b0};
    vecs[14] = '{1'b1, 3'b000, 1'b1, 2'd3, 3'b010, 1'b0, 3'd3, 1'b0};
    vecs[15] = '{1'b1, 3'b000, 1'b1, 2'd0, 3'b110, 1'b1, 3'd4, 1'b0};
    vecs[16] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 3'd3, 1'b0};

    wr_rst_n = 1'b1;
    applyStimulus(1'b0, 3'b000);
    #1 wr_rst_n = 1'b0;
    #1;
    checkOutput("reset", 2'd0, 3'b000, 1'b0, 3'd0, 1'b0);
    checkValue("reset mem_en idle", 32'(wr_if.wr_mem_en), 32'd0);
    wr_if.wr_en = 1'b1;
    #1;
    checkValue("reset mem_en follows wr_en", 32'(wr_if.wr_mem_en), 32'd1);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    applyStimulus(1'b0, 3'b000);
    $display("[TB] reset released");

`ifndef FIFO_WR_PTR_SYNC_EN
    for (int i = 0; i < 17; i++) begin
      stepAndCheck($sformatf("vec%0d", i), vecs[i].wr_en, vecs[i].rd, vecs[i].exp_mem_en,
                   vecs[i].exp_addr, vecs[i].exp_gray, vecs[i].exp_full,
                   vecs[i].exp_level, vecs[i].exp_ovf);
    end

    stepAndCheck("refill", 1'b1, 3'b001, 1'b1, 2'd1, 3'b111, 1'b1, 3'd4, 1'b0);
    stepAndCheck("ovf pending", 1'b1, 3'b001, 1'b0, 2'd1, 3'b111, 1'b1, 3'd4, 1'b1);
    #3 wr_rst_n = 1'b0;
    #1;
    checkOutput("midreset", 2'd0, 3'b000, 1'b0, 3'd0, 1'b0);
    checkValue("midreset mem_en", 32'(wr_if.wr_mem_en), 32'd1);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    stepAndCheck("first write", 1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 3'd1, 1'b0);
`else
    stepAndCheck("sfill1", 1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 3'd1, 1'b0);
    stepAndCheck("sfill2", 1'b1, 3'b000, 1'b1, 2'd2, 3'b011, 1'b0, 3'd2, 1'b0);
    stepAndCheck("sfill3", 1'b1, 3'b000, 1'b1, 2'd3, 3'b010, 1'b0, 3'd3, 1'b0);
    stepAndCheck("sfill4", 1'b1, 3'b000, 1'b1, 2'd0, 3'b110, 1'b1, 3'd4, 1'b0);
    stepAndCheck("srel1", 1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b0);
    stepAndCheck("srel2", 1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b0);
    stepAndCheck("srel3", 1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 3'd3, 1'b0);
    #3 wr_rst_n = 1'b0;
    #1;
    checkOutput("smidreset", 2'd0, 3'b000, 1'b0, 3'd0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ptr_gen.md
# fifo_wr_ptr_gen

Write-side pointer generator for the asynchronous FIFO. It holds the binary write pointer and encodes it into a registered Gray pointer for transfer to the read clock domain. It decodes the read-domain Gray pointer back to binary to produce the registered `full`, fill-level and overflow status. It sits in the write clock domain between the write port and the dual-port memory, and is the binary-to-Gray counterpart of the read-side pointer decode.

## Interface
- `ADDR_WIDTH`, default 4: memory address width.
  - FIFO depth is 2^ADDR_WIDTH.
  - Pointer width is ADDR_WIDTH+1.
  - Legal range is ≥ 2.
- `wr_clk`  input  1  write-domain clock.
- `wr_rst_n`  input  1  reset; asynchronous, active-low.
- `wr_en`  input  1  write request, sampled on rising `wr_clk`.
- `rd_ptr_gray`  input  ADDR_WIDTH+1  read pointer (Gray) from the read domain.
- `wr_addr`  output  ADDR_WIDTH  memory write address, equal to `wr_bin[ADDR_WIDTH-1:0]`.
- `wr_ptr_gray`  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `full`  output  1  registered full flag.
- `wr_level`  output  ADDR_WIDTH+1  registered fill level, range 0..2^ADDR_WIDTH.
- `overflow`  output  1  one-cycle pulse when a write is rejected.
- `wr_mem_en`  output  1  combinational `wr_en & ~full`; memory write strobe.

## Operation
- Internal `wr_bin` is a binary register of ADDR_WIDTH+1 bits.
- `rq` is the read pointer as used in this domain (see Configuration).
- On each rising `wr_clk`, with `inc = wr_en & ~full`:
  - `wr_bin_next = wr_bin + inc`, modulo 2^(ADDR_WIDTH+1). It wraps silently from all-ones to 0.
  - `wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1)`.
  - `wr_bin <= wr_bin_next`; `wr_ptr_gray <= wr_gray_next`. Both registers update on the same edge, so `wr_ptr_gray` is always the glitch-free Gray code of `wr_bin`.
  - `full <= (wr_gray_next == {~rq[A:A-1], rq[A-2:0]})`, where A = ADDR_WIDTH.
  - `wr_level <= wr_bin_next - g2b(rq)`, modulo 2^(A+1). `g2b` is bitwise prefix-XOR from the MSB: bit i = XOR of `rq[A:i]`.
  - `overflow <= wr_en & full`.
- A write with `full`=1 does not advance any pointer. It does not corrupt memory, because `wr_mem_en`=0.
- `wr_en` held high while full produces `overflow`=1 on every such cycle.
- Simultaneous write and read-pointer change: both take effect in the same update. `full` and `wr_level` reflect both.
- `full` deassertion is pessimistic. It occurs only after the advanced read pointer is visible in `rq`. `full` never deasserts early.
- No state machine; the block is a pointer register pipeline plus status registers.

## Timing
- Reset (`wr_rst_n`=0, asynchronous): all outputs clear immediately.
  - `wr_bin`=0, `wr_ptr_gray`=0, `wr_addr`=0.
  - `full`=0, `wr_level`=0, `overflow`=0.
  - Synchronizer flops (if present) = 0.
- Reset deassertion is taken synchronously by the surrounding design. The first accepted write is on the first edge with `wr_rst_n`=1.
- Write latency:
  - Memory writes at `wr_addr` on the edge where `wr_mem_en`=1.
  - `wr_addr` and `wr_ptr_gray` show the next slot after that same edge.
- `full` asserts in the cycle after the edge that accepts the 2^A-th outstanding write. No write is accepted in that cycle.
- `rd_ptr_gray` to `full`/`wr_level` latency is 1 cycle without the synchronizer, 3 cycles with it.
- Reset mid-operation: pointers return to 0 at once. A pending `overflow` pulse is cleared.

## Configuration
- Macro `FIFO_WR_PTR_SYNC_EN`.
- Defined: the block instantiates a 2-flop synchronizer on `wr_clk`, and `rq` is the second flop's output. `rd_ptr_gray` may come directly from the read-domain register.
- Undefined: `rq = rd_ptr_gray` directly, and the integrator must synchronize externally.
- Functional behaviour is otherwise identical. Only the latency differs (+2 cycles).

## Test plan
All scenarios use ADDR_WIDTH=2 with the macro undefined unless stated.

- Reset check: assert `wr_rst_n`=0 mid-cycle. Required: all outputs 0 without waiting for a clock edge, and `wr_mem_en`=`wr_en`.
- Fill: with `rd_ptr_gray`=000, do 4 back-to-back writes. Required:
  - `wr_ptr_gray` sequence 001, 011, 010, 110.
  - `wr_addr` sequence 1, 2, 3, 0.
  - After the 4th edge, `full`=1 and `wr_level`=4.
- Overflow: from full, hold `wr_en`=1 for 2 cycles. Required: `overflow`=1 for 2 cycles, `wr_ptr_gray` stays 110, `wr_mem_en`=0.
- Drain and release: from full, set `rd_ptr_gray`=001. Required:
  - Next edge: `full`=0, `wr_level`=3.
  - Repeat with `FIFO_WR_PTR_SYNC_EN` defined: `full` falls 3 edges later.
- Simultaneous write and read: with `wr_level`=3, `rd_ptr_gray` advancing 001→011 and `wr_en`=1 on the same edge. Required: `wr_level`=3, `full`=0.
- Wrap: interleave writes and read-pointer updates for 12 writes. Required:
  - Gray pointer passes 100 (bin 7) → 000 (bin 0).
  - No spurious `full`, and `wr_level` stays consistent with the reference count.
